// File: rtl/ov7670_yuv_capture.sv
// OV7670 YUV422 capture: waits for camera configuration, discards settling
// frames, then pairs camera bytes into 16-bit words with X/Y coordinates and
// frame/line markers for the downstream gesture pipeline.
module ov7670_yuv_capture #(
    parameter int H_DISP     = 640,
    parameter int V_DISP     = 480,
    parameter int FRAME_SKIP = 10
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iConfig_Done,
    input  logic        iCMOS_VSYNC,
    input  logic        iCMOS_HREF,
    input  logic [7:0]  iCMOS_DATA,
    output logic [15:0] oPixel_Data,
    output logic        oPixel_Valid,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oFrame_Start,
    output logic        oLine_End,
    output logic        oFrame_Ready,
    output logic        oLine_Err
);

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        SKIP     = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    localparam logic [10:0] H_LIM     = 11'(H_DISP);
    localparam logic [9:0]  V_LIM     = 10'(V_DISP);
    localparam logic [7:0]  SKIP_LAST = 8'(FRAME_SKIP - 1);

    // Column counter holds at its maximum instead of wrapping on runaway lines
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // Row counter saturates at 1023
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    logic        cfg_meta_q, cfg_s_q;
    logic        vs_d_q, href_d_q;
    logic        vs_rise, href_fall;

    state_t      state_q, state_d;
    logic [7:0]  skip_cnt_q, skip_cnt_d;
    logic [10:0] x_cnt_q, x_cnt_d;
    logic [9:0]  y_cnt_q, y_cnt_d;
    logic        byte_flag_q, byte_flag_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  ox_q, ox_d;
    logic [9:0]  oy_q, oy_d;
    logic        frame_start_q, frame_start_d;
    logic        line_end_q, line_end_d;
    logic        frame_ready_q, frame_ready_d;
    logic        line_err_q, line_err_d;

    // Two-flop synchronizer for config-done plus one-cycle delayed syncs for edge detect
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cfg_meta_q <= 1'b0;
            cfg_s_q    <= 1'b0;
            vs_d_q     <= 1'b0;
            href_d_q   <= 1'b0;
        end else begin
            cfg_meta_q <= iConfig_Done;
            cfg_s_q    <= cfg_meta_q;
            vs_d_q     <= iCMOS_VSYNC;
            href_d_q   <= iCMOS_HREF;
        end
    end

    assign vs_rise   = iCMOS_VSYNC & ~vs_d_q;
    assign href_fall = ~iCMOS_HREF & href_d_q;

    // Next-state, byte pairing, counters and registered-output computation
    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        byte_flag_d   = byte_flag_q;
        hi_d          = hi_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = 1'b0;
        ox_d          = ox_q;
        oy_d          = oy_q;
        frame_start_d = 1'b0;
        line_end_d    = 1'b0;
        frame_ready_d = frame_ready_q;
        line_err_d    = line_err_q;

        if (!cfg_s_q) begin
            // Losing configuration aborts everything except the sticky error
            state_d       = WAIT_CFG;
            skip_cnt_d    = 8'd0;
            x_cnt_d       = 11'd0;
            y_cnt_d       = 10'd0;
            byte_flag_d   = 1'b0;
            frame_ready_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_CFG: begin
                    state_d    = SKIP;
                    skip_cnt_d = 8'd0;
                end
                SKIP: begin
                    if (vs_rise) begin
                        if (skip_cnt_q == SKIP_LAST) begin
                            // The entering VSYNC edge also starts the first captured frame
                            state_d       = CAPTURE;
                            frame_ready_d = 1'b1;
                            frame_start_d = 1'b1;
                            x_cnt_d       = 11'd0;
                            y_cnt_d       = 10'd0;
                            byte_flag_d   = 1'b0;
                        end else begin
                            skip_cnt_d = skip_cnt_q + 8'd1;
                        end
                    end
                end
                CAPTURE: begin
                    frame_ready_d = 1'b1;
                    if (iCMOS_HREF) begin
                        byte_flag_d = ~byte_flag_q;
                        if (!byte_flag_q) begin
                            hi_d = iCMOS_DATA;
                        end else begin
                            pix_data_d  = {hi_q, iCMOS_DATA};
                            ox_d        = x_cnt_q[9:0];
                            oy_d        = y_cnt_q;
                            // Out-of-window words are counted but not presented
                            pix_valid_d = (x_cnt_q < H_LIM) && (y_cnt_q < V_LIM);
                            x_cnt_d     = sat_inc11(x_cnt_q);
                        end
                    end else begin
                        // An odd trailing byte is discarded at line end
                        byte_flag_d = 1'b0;
                    end

                    if (vs_rise) begin
                        x_cnt_d       = 11'd0;
                        y_cnt_d       = 10'd0;
                        frame_start_d = 1'b1;
                    end else if (href_fall) begin
                        line_end_d = 1'b1;
                        if (x_cnt_q != H_LIM && x_cnt_q != 11'd0) begin
                            line_err_d = 1'b1;
                        end
                        x_cnt_d = 11'd0;
                        if (x_cnt_q != 11'd0) begin
                            y_cnt_d = sat_inc10(y_cnt_q);
                        end
                    end
                end
                default: begin
                    state_d = WAIT_CFG;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q       <= WAIT_CFG;
            skip_cnt_q    <= 8'd0;
            x_cnt_q       <= 11'd0;
            y_cnt_q       <= 10'd0;
            byte_flag_q   <= 1'b0;
            hi_q          <= 8'd0;
            pix_data_q    <= 16'd0;
            pix_valid_q   <= 1'b0;
            ox_q          <= 10'd0;
            oy_q          <= 10'd0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            byte_flag_q   <= byte_flag_d;
            hi_q          <= hi_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            ox_q          <= ox_d;
            oy_q          <= oy_d;
            frame_start_q <= frame_start_d;
            line_end_q    <= line_end_d;
            frame_ready_q <= frame_ready_d;
            line_err_q    <= line_err_d;
        end
    end

    assign oPixel_Data  = pix_data_q;
    assign oPixel_Valid = pix_valid_q;
    assign oX           = ox_q;
    assign oY           = oy_q;
    assign oFrame_Start = frame_start_q;
    assign oLine_End    = line_end_q;
    assign oFrame_Ready = frame_ready_q;
    assign oLine_Err    = line_err_q;

endmodule

// File: tb/tb_ov7670_yuv_capture.sv
// Directed bench for ov7670_yuv_capture with a scoreboard of expected words.
module tb_ov7670_yuv_capture;

    localparam int H = 2;
    localparam int V = 3;
    localparam int SK = 2;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iConfig_Done;
    logic        iCMOS_VSYNC;
    logic        iCMOS_HREF;
    logic [7:0]  iCMOS_DATA;
    logic [15:0] oPixel_Data;
    logic        oPixel_Valid;
    logic [9:0]  oX;
    logic [9:0]  oY;
    logic        oFrame_Start;
    logic        oLine_End;
    logic        oFrame_Ready;
    logic        oLine_Err;

    ov7670_yuv_capture #(.H_DISP(H), .V_DISP(V), .FRAME_SKIP(SK)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iConfig_Done(iConfig_Done),
        .iCMOS_VSYNC(iCMOS_VSYNC), .iCMOS_HREF(iCMOS_HREF), .iCMOS_DATA(iCMOS_DATA),
        .oPixel_Data(oPixel_Data), .oPixel_Valid(oPixel_Valid), .oX(oX), .oY(oY),
        .oFrame_Start(oFrame_Start), .oLine_End(oLine_End),
        .oFrame_Ready(oFrame_Ready), .oLine_Err(oLine_Err)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int fs_cnt = 0;
    logic ready_seen = 1'b0;
    logic [35:0] exp_q[$];
    logic cap = 1'b0;
    int ey = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare any presented word against the scoreboard and tally markers
    task automatic sample();
        if (oPixel_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_valid: observed word %h x %0d y %0d expected none",
                           oPixel_Data, oX, oY);
                end
            end else begin
                chk("word_data_x_y", {28'd0, oPixel_Data, oX, oY}, {28'd0, exp_q.pop_front()});
            end
        end
        if (oFrame_Start === 1'b1) fs_cnt++;
        if (oFrame_Ready === 1'b1) ready_seen = 1'b1;
    endtask

    task automatic cyc();
        @(negedge iCLK);
        sample();
    endtask

    task automatic vs_on();
        iCMOS_VSYNC = 1'b1;
        cyc();
    endtask

    task automatic vs_off();
        cyc();
        iCMOS_VSYNC = 1'b0;
        cyc();
        cyc();
        if (cap) ey = 0;
    endtask

    // Drive n bytes (taken MSB-first from bytes) as one HREF line
    task automatic send_line(input int n, input logic [63:0] bytes);
        logic [7:0] hi;
        logic exp_v;
        hi = 8'd0;
        for (int i = 0; i < n; i++) begin
            iCMOS_HREF = 1'b1;
            iCMOS_DATA = bytes[63 - 8*i -: 8];
            exp_v = 1'b0;
            if (i % 2 == 0) begin
                hi = iCMOS_DATA;
            end else if (cap && (i / 2) < H && ey < V) begin
                exp_v = 1'b1;
                exp_q.push_back({hi, iCMOS_DATA, 10'(i / 2), 10'(ey)});
            end
            cyc();
            if (exp_v) chk("valid_latency", {63'd0, oPixel_Valid}, 64'd1);
        end
        iCMOS_HREF = 1'b0;
        iCMOS_DATA = 8'h00;
        cyc();
        chk("line_end", {63'd0, oLine_End}, {63'd0, cap});
        cyc();
        cyc();
        if (cap && n >= 2) ey = (ey == 1023) ? ey : ey + 1;
    endtask

    initial begin
        iRST_N = 1'b0;
        iConfig_Done = 1'b0;
        iCMOS_VSYNC = 1'b0;
        iCMOS_HREF = 1'b0;
        iCMOS_DATA = 8'h00;
        repeat (3) @(negedge iCLK);
        chk("reset_outputs", {9'd0, oPixel_Data, oPixel_Valid, oX, oY, oFrame_Start,
                              oLine_End, oFrame_Ready, oLine_Err}, 64'd0);
        iRST_N = 1'b1;

        // Configuration not done: three frames produce nothing
        for (int f = 0; f < 3; f++) begin
            vs_on();
            vs_off();
            send_line(4, 64'hA1A2A3A4_00000000);
            send_line(4, 64'hB1B2B3B4_00000000);
        end
        chk("idle_frame_start", 64'(fs_cnt), 64'd0);
        chk("idle_ready", {63'd0, ready_seen}, 64'd0);

        // Configuration done: first VSYNC skipped, second enters capture
        iConfig_Done = 1'b1;
        repeat (4) cyc();
        vs_on();
        chk("ready_after_skip1", {63'd0, oFrame_Ready}, 64'd0);
        vs_off();
        fs_cnt = 0;
        vs_on();
        chk("ready_on_entry", {63'd0, oFrame_Ready}, 64'd1);
        chk("frame_start_on_entry", {63'd0, oFrame_Start}, 64'd1);
        cap = 1'b1;
        vs_off();
        vs_on();
        vs_off();

        // Nominal line
        send_line(4, 64'h12345678_00000000);
        chk("line_err_clean", {63'd0, oLine_Err}, 64'd0);

        // Over-long line: third word suppressed, sticky error raised
        send_line(6, 64'hC1C2C3C4C5C6_0000);
        chk("line_err_long", {63'd0, oLine_Err}, 64'd1);

        // Odd byte count: trailing byte dropped
        send_line(5, 64'hD1D2D3D4D5_000000);
        // Row beyond V: words suppressed, line still marked
        send_line(4, 64'hE1E2E3E4_00000000);

        // New frame: first word pairs cleanly, error stays sticky
        vs_on();
        vs_off();
        send_line(4, 64'h9ABCDEF0_00000000);
        chk("line_err_sticky", {63'd0, oLine_Err}, 64'd1);
        chk("frame_start_count", 64'(fs_cnt), 64'd3);

        // Configuration lost mid-line: only the word already in flight emerges
        iCMOS_HREF = 1'b1;
        iCMOS_DATA = 8'h11;
        iConfig_Done = 1'b0;
        cyc();
        iCMOS_DATA = 8'h22;
        exp_q.push_back({16'h1122, 10'd0, 10'(ey)});
        cyc();
        iCMOS_DATA = 8'h33;
        cyc();
        chk("ready_drop", {63'd0, oFrame_Ready}, 64'd0);
        cap = 1'b0;
        iCMOS_DATA = 8'h44;
        cyc();
        iCMOS_DATA = 8'h55;
        cyc();
        iCMOS_HREF = 1'b0;
        cyc();
        chk("no_line_end_after_drop", {63'd0, oLine_End}, 64'd0);
        chk("err_kept_after_drop", {63'd0, oLine_Err}, 64'd1);

        // Re-assert: skip frames again, then resume at row 0
        iConfig_Done = 1'b1;
        repeat (4) cyc();
        vs_on();
        vs_off();
        send_line(4, 64'hF1F2F3F4_00000000);
        chk("ready_during_reskip", {63'd0, oFrame_Ready}, 64'd0);
        vs_on();
        chk("ready_resume", {63'd0, oFrame_Ready}, 64'd1);
        cap = 1'b1;
        vs_off();
        send_line(4, 64'h0102ABCD_00000000);
        chk("resume_row", {54'd0, oY}, 64'd0);

        // Asynchronous reset mid-line clears outputs immediately
        iCMOS_HREF = 1'b1;
        iCMOS_DATA = 8'h77;
        cyc();
        chk("ready_before_reset", {63'd0, oFrame_Ready}, 64'd1);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        #2;
        iRST_N = 1'b0;
        #1;
        chk("async_reset_outputs", {9'd0, oPixel_Data, oPixel_Valid, oX, oY, oFrame_Start,
                                    oLine_End, oFrame_Ready, oLine_Err}, 64'd0);
        cap = 1'b0;
        iCMOS_HREF = 1'b0;
        repeat (2) cyc();
        iRST_N = 1'b1;
        repeat (4) cyc();
        ready_seen = 1'b0;
        vs_on();
        vs_off();
        send_line(4, 64'h5A5B5C5D_00000000);
        chk("ready_after_reset_skip", {63'd0, ready_seen}, 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
